// File: rtl/pipe_mem_sched.sv
// pipe_mem_sched: sequencing controller for the 5-stage core.
// Shares the single RAM port between instruction fetch and MEM-stage data
// access (data first). It also drives the pipeline latch write-enable and
// flush controls and the PC write enable, and holds the core once it halts.
module pipe_mem_sched (
  input  logic CLK,
  input  logic nRST,
  input  logic iREN,
  input  logic dREN,
  input  logic dWEN,
  input  logic ram_ready,
  input  logic load_hazard,
  input  logic branch_taken,
  input  logic halt_in,
  output logic ramREN,
  output logic ramWEN,
  output logic ram_sel_d,
  output logic ihit,
  output logic dhit,
  output logic pc_wen,
  output logic ifid_wen,
  output logic idex_wen,
  output logic exmem_wen,
  output logic memwb_wen,
  output logic ifid_flush,
  output logic idex_flush,
  output logic exmem_flush,
  output logic halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IACC   = 2'd1,
    DACC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state_reg, state_next;
  logic   i_done_reg, i_done_next;
  logic   d_done_reg, d_done_next;
  logic   halt_pend_reg, halt_pend_next;

  logic   dreq;
  logic   halting;
  logic   i_eff, d_eff;
  logic   advance;
  logic   arb_i_done, arb_d_done;
  state_t arb_pick;

  // State register, done flags and sticky halt request
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg     <= IDLE;
      i_done_reg    <= 1'b0;
      d_done_reg    <= 1'b0;
      halt_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      i_done_reg    <= i_done_next;
      d_done_reg    <= d_done_next;
      halt_pend_reg <= halt_pend_next;
    end
  end

  // Hit detection, advance condition and arbitration choice
  always_comb begin
    dreq    = dREN | dWEN;
    halting = halt_in | halt_pend_reg;
    ihit    = (state_reg == IACC) & ram_ready;
    dhit    = (state_reg == DACC) & ram_ready;
    d_eff   = ~dreq | d_done_reg | dhit;
    i_eff   = ~iREN | i_done_reg | ihit;
    // A halt in flight discards the returning access, so nothing advances.
    // Latch controls are also held low while reset is asserted.
    advance = d_eff & i_eff & (state_reg != HALTED) & ~halting & nRST;

    // On advance the completed accesses belong to the old instruction, so
    // the next grant sees clean flags and back-to-back accesses need no bubble.
    arb_d_done = advance ? 1'b0 : (d_done_reg | dhit);
    arb_i_done = advance ? 1'b0 : (i_done_reg | ihit);

    arb_pick = IDLE;
    if (dreq & ~arb_d_done) begin
      arb_pick = DACC;
    end else if (iREN & ~arb_i_done) begin
      arb_pick = IACC;
    end
  end

  // Next-state logic; a grant is held until the RAM reports ready
  always_comb begin
    state_next     = state_reg;
    i_done_next    = i_done_reg;
    d_done_next    = d_done_reg;
    halt_pend_next = halt_pend_reg | halt_in;

    case (state_reg)
      IDLE: begin
        state_next = halting ? HALTED : arb_pick;
      end
      IACC, DACC: begin
        if (ram_ready) begin
          state_next = halting ? HALTED : arb_pick;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Clearing on advance wins over a hit landing in the same cycle
    if (advance) begin
      i_done_next = 1'b0;
      d_done_next = 1'b0;
    end else begin
      if (ihit) i_done_next = 1'b1;
      if (dhit) d_done_next = 1'b1;
    end
  end

  // RAM strobes and port select follow the current grant
  always_comb begin
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ram_sel_d = 1'b0;
    halted    = 1'b0;
    case (state_reg)
      IACC: begin
        ramREN = 1'b1;
      end
      DACC: begin
        ramWEN    = dWEN;
        ramREN    = ~dWEN;
        ram_sel_d = 1'b1;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Pipeline latch controls: branch flush beats load-use stall
  always_comb begin
    pc_wen      = 1'b0;
    ifid_wen    = 1'b0;
    idex_wen    = 1'b0;
    exmem_wen   = 1'b0;
    memwb_wen   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (advance) begin
      pc_wen    = 1'b1;
      ifid_wen  = 1'b1;
      idex_wen  = 1'b1;
      exmem_wen = 1'b1;
      memwb_wen = 1'b1;
      if (branch_taken) begin
        // Squash the three wrong-path instructions; PC takes the target.
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_hazard) begin
        // Hold PC and IF/ID, inject a bubble into ID/EX.
        pc_wen     = 1'b0;
        ifid_wen   = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mem_sched.sv
// Directed bench for pipe_mem_sched: a cycle-by-cycle vector table plus
// hand-written halt and mid-access reset sequences.
module tb_pipe_mem_sched;

  logic CLK = 1'b0;
  logic nRST, iREN, dREN, dWEN, ram_ready, load_hazard, branch_taken, halt_in;
  logic ramREN, ramWEN, ram_sel_d, ihit, dhit, pc_wen;
  logic ifid_wen, idex_wen, exmem_wen, memwb_wen;
  logic ifid_flush, idex_flush, exmem_flush, halted;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  pipe_mem_sched dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .ram_ready(ram_ready), .load_hazard(load_hazard),
    .branch_taken(branch_taken), .halt_in(halt_in),
    .ramREN(ramREN), .ramWEN(ramWEN), .ram_sel_d(ram_sel_d),
    .ihit(ihit), .dhit(dhit), .pc_wen(pc_wen),
    .ifid_wen(ifid_wen), .idex_wen(idex_wen), .exmem_wen(exmem_wen),
    .memwb_wen(memwb_wen), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .halted(halted)
  );

  // Observed outputs packed in a fixed order
  logic [13:0] obs;
  assign obs = {ramREN, ramWEN, ram_sel_d, ihit, dhit, pc_wen, ifid_wen,
                idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush,
                exmem_flush, halted};

  localparam logic [13:0] RREN = 14'h2000;
  localparam logic [13:0] RWEN = 14'h1000;
  localparam logic [13:0] SEL  = 14'h0800;
  localparam logic [13:0] IHIT = 14'h0400;
  localparam logic [13:0] DHIT = 14'h0200;
  localparam logic [13:0] WENS = 14'h01F0; // pc, ifid, idex, exmem, memwb
  localparam logic [13:0] HAZ  = 14'h0074; // idex, exmem, memwb wen + idex_flush
  localparam logic [13:0] BR   = 14'h01FE; // all wens + three flushes
  localparam logic [13:0] HLT  = 14'h0001;

  // Input byte: {nRST, iREN, dREN, dWEN, ram_ready, load_hazard, branch_taken, halt_in}
  typedef struct {
    logic [7:0]  in;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs [17];

  // Apply inputs just after the rising edge, sample at the falling edge
  task automatic cycle(input logic [7:0] in, input logic [13:0] exp,
                       input bit check, input string name);
    @(posedge CLK);
    #1;
    {nRST, iREN, dREN, dWEN, ram_ready, load_hazard, branch_taken, halt_in} = in;
    @(negedge CLK);
    if (check) begin
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL %s: got %b expected %b", name, obs, exp);
      end else begin
        $display("ok   %s: %b", name, obs);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    {nRST, iREN, dREN, dWEN, ram_ready, load_hazard, branch_taken, halt_in} = 8'h00;

    vecs[0]  = '{8'b0000_0000, 14'h0};                   // reset state
    vecs[1]  = '{8'b1110_0000, 14'h0};                   // IDLE, i+d request
    vecs[2]  = '{8'b1110_0000, RREN | SEL};              // DACC wait
    vecs[3]  = '{8'b1110_0000, RREN | SEL};              // DACC wait
    vecs[4]  = '{8'b1110_1000, RREN | SEL | DHIT};       // dhit, no advance
    vecs[5]  = '{8'b1110_0000, RREN};                    // IACC wait
    vecs[6]  = '{8'b1100_1000, RREN | IHIT | WENS};      // ihit, single advance
    vecs[7]  = '{8'b1100_1000, RREN | IHIT | WENS};      // streaming fetch
    vecs[8]  = '{8'b1100_1000, RREN | IHIT | WENS};
    vecs[9]  = '{8'b1100_1100, RREN | IHIT | HAZ};       // load-use stall
    vecs[10] = '{8'b1100_1000, RREN | IHIT | WENS};      // normal again
    vecs[11] = '{8'b1100_1110, RREN | IHIT | BR};        // branch beats hazard
    vecs[12] = '{8'b1100_1000, RREN | IHIT | WENS};
    vecs[13] = '{8'b1111_1000, RREN | IHIT};             // fetch done, store pending
    vecs[14] = '{8'b1111_1000, RWEN | SEL | DHIT | WENS};// store commits, advance
    vecs[15] = '{8'b1101_1000, RWEN | SEL | DHIT};       // no bubble: store again
    vecs[16] = '{8'b1100_1000, RREN | IHIT | WENS};      // fetch completes pair

    // Two reset edges bring the FSM to a known state
    cycle(8'h00, 14'h0, 1'b0, "pre_reset");
    cycle(8'h00, 14'h0, 1'b0, "pre_reset");

    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].in, vecs[i].exp, 1'b1, $sformatf("vec%0d", i));
    end

    // Halt during a fetch: access completes late, fetch is discarded
    for (int i = 0; i < 3; i++) begin
      cycle(8'b1100_0001, RREN, 1'b1, $sformatf("halt_wait%0d", i));
    end
    cycle(8'b1100_1001, RREN | IHIT, 1'b1, "halt_ready");
    for (int i = 0; i < 10; i++) begin
      cycle(8'b1110_1000, HLT, 1'b1, $sformatf("halted%0d", i));
    end

    // Reset from HALTED, then reset in the middle of a store
    cycle(8'b0000_0000, 14'h0, 1'b0, "rst_a");
    cycle(8'b0000_0000, 14'h0, 1'b1, "rst_from_halt");
    cycle(8'b1011_0000, 14'h0, 1'b1, "idle_store_req");
    cycle(8'b1011_0000, RWEN | SEL, 1'b1, "dacc_wait");
    cycle(8'b0011_0000, RWEN | SEL, 1'b1, "rst_mid_dacc");
    cycle(8'b1100_1000, 14'h0, 1'b1, "after_rst_idle");
    cycle(8'b1100_1000, RREN | IHIT | WENS, 1'b1, "fetch_resume0");
    cycle(8'b1100_1000, RREN | IHIT | WENS, 1'b1, "fetch_resume1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
